countdown_monitor: RTL and testbench

//   Synchronous consumer of the 4-bit ripple countdown value (cd) and fire flag from the gate-level counter.

---
 rtl/countdown_pkg.sv | 24 ++
 rtl/countdown_monitor_if.sv | 30 +++
 rtl/cd_stabilizer.sv | 54 +++++
 rtl/countdown_monitor.sv | 105 ++++++++++
 tb/tb_countdown_monitor.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_pkg
// Description : State encoding, blank code and hex segment table for the
//               countdown monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_COUNTING = 2'd2;
    localparam logic [1:0] S_FIRED    = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; element [n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage
`default_nettype wire

// File: rtl/countdown_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_monitor_if
// Description : Count input, launch controls and status outputs of the
//               countdown monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown_monitor_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] cd_in;
    logic             arm;
    logic             abort;
    logic [WIDTH-1:0] cd_sync;
    logic [6:0]       seg;
    logic             fire;
    logic [1:0]       state;
    logic             err;

    modport master (
        output cd_in, arm, abort,
        input  cd_sync, seg, fire, state, err
    );

    modport slave (
        input  cd_in, arm, abort,
        output cd_sync, seg, fire, state, err
    );
endinterface
`default_nettype wire

// File: rtl/cd_stabilizer.sv
`default_nettype none
// ============================================================================
// Module      : cd_stabilizer
// Description : Two-flop bus synchroniser plus stability filter for the
//               skewed ripple-counter value; strobes accept on each new value.
// Revision    : 1.0 - initial release
// ============================================================================
module cd_stabilizer #(
    parameter int WIDTH      = 4,
    parameter int STABLE_CNT = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] cd_in,
    output logic      [WIDTH-1:0] cd_sync,
    output logic                  accept
);
    localparam int             CW        = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]  C_CNT_MAX = CW'(STABLE_CNT - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_cand;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
            cd_sync <= '0;
            accept  <= 1'b0;
        end else begin
            r_s1   <= cd_in;
            r_s2   <= r_s1;
            accept <= 1'b0;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= CW'(1);
            end else begin
                if (r_cnt < C_CNT_MAX) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                // Any sample skewed mid-ripple restarts the count above.
                if (r_cnt >= C_CNT_MAX && r_cand != cd_sync) begin
                    cd_sync <= r_cand;
                    accept  <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/countdown_monitor.sv
`default_nettype none
// ============================================================================
// Module      : countdown_monitor
// Description : Stabilised countdown consumer: sequence checker, 7-segment
//               digit and arm/abort launch FSM with a held fire pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_monitor
    import countdown_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int STABLE_CNT = 2,
    parameter int FIRE_HOLD  = 8
) (
    input wire logic            clk,
    input wire logic            rst,
    countdown_monitor_if.slave  bus
);
    localparam int            HW          = $clog2(FIRE_HOLD + 1);
    localparam logic [HW-1:0] C_HOLD_LAST = HW'(FIRE_HOLD - 1);

    logic [WIDTH-1:0] w_cd_sync;
    logic             w_accept;
    logic [WIDTH-1:0] w_prev_dec;
    logic             w_zero;

    logic [1:0]       r_state;
    logic             r_fire;
    logic             r_err;
    logic [HW-1:0]    r_hold;
    logic [WIDTH-1:0] r_prev;
    logic [6:0]       r_seg;

    cd_stabilizer #(
        .WIDTH      (WIDTH),
        .STABLE_CNT (STABLE_CNT)
    ) u_stab (
        .clk     (clk),
        .rst     (rst),
        .cd_in   (bus.cd_in),
        .cd_sync (w_cd_sync),
        .accept  (w_accept)
    );

    assign w_prev_dec = r_prev - WIDTH'(1);
    assign w_zero     = (w_cd_sync == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fire  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= '0;
            r_prev  <= '0;
            r_seg   <= SEG_BLANK;
        end else begin
            if (w_accept) begin
                r_seg <= SEG_TABLE[4'(w_cd_sync)];
            end
            case (r_state)
                S_IDLE: begin
                    if (!bus.abort && bus.arm) begin
                        r_state <= S_ARMED;
                        r_err   <= 1'b0;
                    end
                end
                S_ARMED, S_COUNTING: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        // The first value after arming is only a reference.
                        if (r_state == S_COUNTING && w_cd_sync != w_prev_dec) begin
                            r_err <= 1'b1;
                        end
                        r_prev <= w_cd_sync;
                        if (w_zero) begin
                            r_state <= S_FIRED;
                            r_fire  <= 1'b1;
                            r_hold  <= '0;
                        end else begin
                            r_state <= S_COUNTING;
                        end
                    end
                end
                S_FIRED: begin
                    if (r_hold == C_HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_fire  <= 1'b0;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cd_sync = w_cd_sync;
    assign bus.seg     = r_seg;
    assign bus.fire    = r_fire;
    assign bus.state   = r_state;
    assign bus.err     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_countdown_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_monitor
// Description : Directed self-checking bench; accepted counts are matched
//               against a queue of expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_monitor;
    logic clk;
    logic rst;

    countdown_monitor_if #(.WIDTH(4)) bus ();

    countdown_monitor #(
        .WIDTH      (4),
        .STABLE_CNT (2),
        .FIRE_HOLD  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_cmp;
    int         n_err;
    int         fire_hi;
    logic [3:0] exp_q[$];
    logic [3:0] last_sync;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_cd(input logic [3:0] v);
        bus.cd_in = v;
        exp_q.push_back(v);
    endtask

    // Scoreboard: every change of the accepted count must match the next queued value.
    always @(negedge clk) begin
        if (rst) begin
            last_sync = bus.cd_sync;
        end else begin
            if (bus.fire === 1'b1) fire_hi++;
            if (bus.cd_sync !== last_sync) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 32'(bus.cd_sync), 32'(last_sync));
                end else begin
                    chk("accept_value", 32'(bus.cd_sync), 32'(exp_q.pop_front()));
                end
                last_sync = bus.cd_sync;
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        fire_hi   = 0;
        last_sync = '0;
        rst       = 1'b1;
        bus.cd_in = 4'h9;
        bus.arm   = 1'b0;
        bus.abort = 1'b0;

        // Reset
        tick(3);
        chk("rst_cd_sync", 32'(bus.cd_sync), 0);
        chk("rst_seg",     32'(bus.seg),     32'h7F);
        chk("rst_fire",    32'(bus.fire),    0);
        chk("rst_state",   32'(bus.state),   0);
        chk("rst_err",     32'(bus.err),     0);
        bus.cd_in = 4'h0;
        rst       = 1'b0;
        tick(3);

        // Latency 0 -> 5
        drive_cd(4'h5);
        tick(3);
        chk("lat_early", 32'(bus.cd_sync), 0);
        tick(1);
        chk("lat_exact", 32'(bus.cd_sync), 5);
        chk("seg_lag",   32'(bus.seg),     32'h7F);
        tick(1);
        chk("seg_5",     32'(bus.seg),     32'h12);

        // One-cycle glitch on a stable 3
        drive_cd(4'h3);
        tick(6);
        chk("glitch_pre", 32'(bus.cd_sync), 3);
        bus.cd_in = 4'h7;
        tick(1);
        bus.cd_in = 4'h3;
        tick(6);
        chk("glitch_post", 32'(bus.cd_sync), 3);
        chk("seg_3",       32'(bus.seg),     32'h30);

        // Launch 3,2,1,0
        drive_cd(4'h4);
        tick(6);
        bus.arm = 1'b1;
        tick(1);
        bus.arm = 1'b0;
        chk("launch_armed", 32'(bus.state), 1);
        drive_cd(4'h3);
        tick(6);
        chk("launch_cnt3", 32'(bus.state), 2);
        drive_cd(4'h2);
        tick(6);
        drive_cd(4'h1);
        tick(6);
        chk("launch_cnt1", 32'(bus.state), 2);
        fire_hi = 0;
        drive_cd(4'h0);
        tick(4);
        chk("launch_prefire", 32'(bus.fire), 0);
        tick(1);
        chk("launch_fired", 32'(bus.state), 3);
        chk("launch_fire",  32'(bus.fire),  1);
        tick(7);
        chk("launch_hold",  32'(bus.fire),  1);
        tick(1);
        chk("launch_idle",  32'(bus.state), 0);
        chk("launch_off",   32'(bus.fire),  0);
        chk("launch_width", 32'(fire_hi),   8);
        chk("launch_err",   32'(bus.err),   0);

        // Sequence error 9,8,5,4 then 0 still fires
        bus.arm = 1'b1;
        tick(1);
        bus.arm = 1'b0;
        drive_cd(4'h9);
        tick(6);
        drive_cd(4'h8);
        tick(6);
        chk("seq_ok", 32'(bus.err), 0);
        drive_cd(4'h5);
        tick(4);
        chk("seq_before", 32'(bus.err), 0);
        tick(1);
        chk("seq_err", 32'(bus.err), 1);
        drive_cd(4'h4);
        tick(6);
        chk("seq_sticky", 32'(bus.err), 1);
        fire_hi = 0;
        drive_cd(4'h0);
        tick(5);
        chk("seq_fired", 32'(bus.state), 3);
        tick(8);
        chk("seq_idle",   32'(bus.state), 0);
        chk("seq_width",  32'(fire_hi),   8);
        chk("seq_keep",   32'(bus.err),   1);
        bus.arm = 1'b1;
        tick(1);
        bus.arm = 1'b0;
        chk("seq_clear",  32'(bus.err),   0);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("abort_armed", 32'(bus.state), 0);

        // Abort on the same cycle as the accept of 0
        bus.arm = 1'b1;
        tick(1);
        bus.arm = 1'b0;
        drive_cd(4'h2);
        tick(6);
        drive_cd(4'h1);
        tick(6);
        chk("abort_counting", 32'(bus.state), 2);
        fire_hi = 0;
        drive_cd(4'h0);
        tick(4);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("abort_state", 32'(bus.state), 0);
        tick(10);
        chk("abort_nofire", 32'(fire_hi), 0);
        chk("abort_err",    32'(bus.err), 0);

        // arm together with abort in IDLE
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        tick(2);
        chk("armabort_idle", 32'(bus.state), 0);
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        tick(2);

        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
